// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Control sequencer for one ALU-class operation at a time. An operation is
//   accepted in IDLE and then runs through EXEC, and for memory operations
//   also MEMWAIT and WB, before a one-cycle DONE.
//
// Parameters
//   MEM_TIMEOUT     maximum MEMWAIT cycles before the memory access is
//                   abandoned (legal 1..15)
//
// Ports
//   Clk             single clock, rising edge
//   Reset           synchronous, active high
//   Start           request to begin an operation
//   OpClass[1:0]    0 ALU, 1 ADDR64, 2 CLR, 3 REPEAT
//   RepeatCount[2:0] REPEAT iteration count, 0 encodes 8
//   MemReady        data-memory completion strobe
//   ALUSrcAControl[2:0] ALU source A: 0 ReadA, 1 constant 64, 2 zero
//   RegWrite        register-file write strobe
//   MemRead         data-memory read request
//   Busy            high whenever the FSM is not IDLE
//   Done            one-cycle completion pulse
//   Error           abort flag, meaningful only while Done is high
//   Iter[2:0]       current REPEAT iteration index
//   DebugState[2:0] raw FSM state for checkers
//
// Handshake: Start is a level request sampled only in IDLE; there is no
// ready back to the requester, Busy low marks the only acceptance window and
// a Start seen in any other state is dropped. MemReady is a completion strobe
// sampled only in MEMWAIT. All outputs are decoded from state and the
// captured operation, never from the inputs directly.

module alu_op_sequencer #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] OpClass,
  input  logic [2:0] RepeatCount,
  input  logic       MemReady,
  output logic [2:0] ALUSrcAControl,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  output logic [2:0] Iter,
  output logic [2:0] DebugState
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] EXEC    = 3'd1;
  localparam logic [2:0] MEMWAIT = 3'd2;
  localparam logic [2:0] WB      = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [1:0] OP_ALU    = 2'd0;
  localparam logic [1:0] OP_ADDR64 = 2'd1;
  localparam logic [1:0] OP_CLR    = 2'd2;
  localparam logic [1:0] OP_REPEAT = 2'd3;

  localparam logic [2:0] SRC_READA = 3'd0;
  localparam logic [2:0] SRC_C64   = 3'd1;
  localparam logic [2:0] SRC_ZERO  = 3'd2;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  logic [2:0] state;
  logic [1:0] opReg;
  logic [2:0] countReg;
  logic [3:0] waitCnt;
  logic [2:0] iterReg;
  logic       abortFlag;
  logic [2:0] lastIter;

  // Index of the final REPEAT iteration. The 3-bit wrap makes a count of 0
  // give 7, which is exactly the "0 means 8" encoding.
  assign lastIter = countReg - 3'd1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      opReg     <= OP_ALU;
      countReg  <= 3'd0;
      waitCnt   <= 4'd0;
      iterReg   <= 3'd0;
      abortFlag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            opReg    <= OpClass;
            countReg <= RepeatCount;
            iterReg  <= 3'd0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          case (opReg)
            OP_ADDR64: begin
              waitCnt <= 4'd0;
              state   <= MEMWAIT;
            end
            OP_REPEAT: begin
              if (iterReg == lastIter) begin
                iterReg <= 3'd0;
                state   <= DONE;
              end else begin
                iterReg <= iterReg + 3'd1;
              end
            end
            default: state <= DONE;
          endcase
        end
        MEMWAIT: begin
          // A completion arriving on the last allowed cycle still counts.
          if (MemReady) begin
            state <= WB;
          end else if (waitCnt == WAIT_LAST) begin
            abortFlag <= 1'b1;
            state     <= DONE;
          end else begin
            waitCnt <= waitCnt + 4'd1;
          end
        end
        WB: state <= DONE;
        DONE: begin
          abortFlag <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ALUSrcAControl = SRC_ZERO;
    RegWrite       = 1'b0;
    MemRead        = 1'b0;
    case (state)
      EXEC: begin
        case (opReg)
          OP_ADDR64: begin
            ALUSrcAControl = SRC_C64;
            MemRead        = 1'b1;
          end
          OP_CLR: begin
            ALUSrcAControl = SRC_ZERO;
            RegWrite       = 1'b1;
          end
          default: begin
            ALUSrcAControl = SRC_READA;
            RegWrite       = 1'b1;
          end
        endcase
      end
      MEMWAIT: begin
        ALUSrcAControl = SRC_C64;
        MemRead        = 1'b1;
      end
      WB: begin
        ALUSrcAControl = SRC_C64;
        RegWrite       = 1'b1;
      end
      default: ;
    endcase
  end

  assign Busy       = (state != IDLE);
  assign Done       = (state == DONE);
  assign Error      = (state == DONE) && abortFlag;
  assign Iter       = iterReg;
  assign DebugState = state;

endmodule
